vga_board_capture: RTL and testbench

VGA_BOARD_CAPTURE -- requirements
Module: vga_board_capture

---
 rtl/vga_board_capture.sv | 233 +++++++++++++++++++++++
 tb/tb_vga_board_capture.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_board_capture.sv
// rtl/vga_board_capture.sv - captures an 8x8 game board from a 640x480@60 VGA pixel stream
//
// Recovers pixel/line position from hsync/vsync, qualifies the timing with a
// line-length lock FSM, samples the centre of every 50x50 cell of a 400x400
// board drawn at (120,40), and publishes the 64-bit board once per cleanly
// locked frame.
//
// Ports:
//   clk         in   1   pixel clock (25.175 MHz nominal), rising edge
//   reset       in   1   synchronous, active-low
//   vga_in      in   8   {hsync,B0,G0,R0,vsync,B1,G1,R1}, syncs active-low
//   board       out  64  last complete captured board, bit = row*8 + col
//   frame_valid out  1   one-clk pulse on the edge that updates board
//   locked      out  1   high while timing lock is held
//   sync_err    out  1   one-clk pulse per lost-lock event
//   live_count  out  7   population count of board (only with VGA_CAPTURE_POPCOUNT_EN)
//
// Build option: define VGA_CAPTURE_POPCOUNT_EN to add the live_count output.
module vga_board_capture (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  vga_in,
    output logic [63:0] board,
    output logic        frame_valid,
    output logic        locked,
    output logic        sync_err
`ifdef VGA_CAPTURE_POPCOUNT_EN
    ,
    output logic [6:0]  live_count
`endif
);

    localparam logic [9:0] H_SYNC_LOAD = 10'd656;
    localparam logic [9:0] H_MAX       = 10'd799;
    localparam logic [9:0] V_SYNC_LOAD = 10'd490;
    localparam logic [9:0] V_MAX       = 10'd524;
    localparam logic [9:0] LINE_LEN    = 10'd800;
    localparam logic [9:0] LLEN_SAT    = 10'd1023;
    localparam logic [6:0] CELLS       = 7'd64;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SYNCED = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      state;
    state_t      state_n;
    logic        err_n;

    logic [7:0]  sync1;
    logic [7:0]  sync2;
    logic [7:0]  vga_d;
    logic        hs_fall;
    logic        vs_fall;
    logic        alive;

    logic [9:0]  hcnt;
    logic [9:0]  vcnt;
    logic [9:0]  llen;
    logic        line_good;
    logic        line_bad;

    logic        col_hit;
    logic        row_hit;
    logic [2:0]  col_idx;
    logic [2:0]  row_idx;
    logic        sample_en;

    logic [63:0] shadow;
    logic [6:0]  sample_cnt;
    logic        frame_clean;
    logic        publish;

    // vga_d is one stage behind sync2 so that the pixel colour it holds lines
    // up with hcnt/vcnt, which are loaded one clock after the sync edge is seen.
    assign hs_fall = vga_d[7] & ~sync2[7];
    assign vs_fall = vga_d[3] & ~sync2[3];

    // Alive colour is R=11, G=01, B=00; everything else reads as dead.
    assign alive = vga_d[0] & vga_d[4] & ~vga_d[1] & vga_d[5] & ~vga_d[2] & ~vga_d[6];

    // llen holds the clock count since the last hsync edge; it resets to 1023
    // so the first edge after reset never qualifies as a good line.
    assign line_good = hs_fall && (llen == LINE_LEN);
    assign line_bad  = (hs_fall && (llen != LINE_LEN)) || (llen == LLEN_SAT);

    assign locked = (state == LOCKED);

    always_comb begin
        col_hit = 1'b0;
        row_hit = 1'b0;
        col_idx = 3'd0;
        row_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (hcnt == 10'(145 + 50 * i)) begin
                col_hit = 1'b1;
                col_idx = 3'(i);
            end
            if (vcnt == 10'(65 + 50 * i)) begin
                row_hit = 1'b1;
                row_idx = 3'(i);
            end
        end
    end

    assign sample_en = col_hit & row_hit;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= SEARCH;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        err_n   = 1'b0;
        case (state)
            SEARCH: begin
                if (line_good) begin
                    state_n = SYNCED;
                end
            end
            SYNCED: begin
                if (line_bad) begin
                    state_n = SEARCH;
                end else if (vs_fall) begin
                    state_n = LOCKED;
                end
            end
            LOCKED: begin
                if (line_bad) begin
                    state_n = SEARCH;
                    err_n   = 1'b1;
                end
            end
            default: begin
                state_n = SEARCH;
            end
        endcase
    end

    // A frame is published only if lock held from the vsync that opened it
    // through the vsync that closes it, and every cell was sampled.
    assign publish = vs_fall && frame_clean && (sample_cnt == CELLS) &&
                     (state == LOCKED) && (state_n == LOCKED);

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1       <= 8'hFF;
            sync2       <= 8'hFF;
            vga_d       <= 8'hFF;
            hcnt        <= 10'd0;
            vcnt        <= 10'd0;
            llen        <= LLEN_SAT;
            shadow      <= 64'd0;
            sample_cnt  <= 7'd0;
            frame_clean <= 1'b0;
            board       <= 64'd0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            sync1 <= vga_in;
            sync2 <= sync1;
            vga_d <= sync2;

            sync_err    <= err_n;
            frame_valid <= publish;

            if (hs_fall) begin
                hcnt <= H_SYNC_LOAD;
            end else if (hcnt == H_MAX) begin
                hcnt <= 10'd0;
            end else begin
                hcnt <= hcnt + 10'd1;
            end

            if (vs_fall) begin
                vcnt <= V_SYNC_LOAD;
            end else if (hs_fall) begin
                vcnt <= (vcnt == V_MAX) ? 10'd0 : vcnt + 10'd1;
            end

            if (hs_fall) begin
                llen <= 10'd1;
            end else if (llen != LLEN_SAT) begin
                llen <= llen + 10'd1;
            end

            if (sample_en) begin
                shadow[{row_idx, col_idx}] <= alive;
            end

            if (vs_fall) begin
                sample_cnt <= 7'd0;
            end else if (sample_en && (sample_cnt != CELLS)) begin
                sample_cnt <= sample_cnt + 7'd1;
            end

            if (vs_fall) begin
                frame_clean <= (state_n == LOCKED);
            end else if (state_n != LOCKED) begin
                frame_clean <= 1'b0;
            end

            if (publish) begin
                board <= shadow;
            end
        end
    end

`ifdef VGA_CAPTURE_POPCOUNT_EN
    function automatic logic [6:0] popcount64(input logic [63:0] v);
        logic [6:0] n;
        n = 7'd0;
        for (int i = 0; i < 64; i++) begin
            n = n + 7'(v[i]);
        end
        return n;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            live_count <= 7'd0;
        end else if (publish) begin
            live_count <= popcount64(shadow);
        end
    end
`endif

endmodule

// File: tb/tb_vga_board_capture.sv
// tb/tb_vga_board_capture.sv - scoreboard bench for vga_board_capture
`timescale 1ns/1ps
module tb_vga_board_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  vga_in;
    logic [63:0] board;
    logic        frame_valid;
    logic        locked;
    logic        sync_err;
`ifdef VGA_CAPTURE_POPCOUNT_EN
    logic [6:0]  live_count;
`endif

    always #20 clk = ~clk;

    vga_board_capture dut (
        .clk         (clk),
        .reset       (reset),
        .vga_in      (vga_in),
        .board       (board),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err)
`ifdef VGA_CAPTURE_POPCOUNT_EN
        ,
        .live_count  (live_count)
`endif
    );

    // U/W board: bits 0,3,8,11,16,19,25,26,35,39,43,47,51,53,55,60,62
    localparam logic [63:0] PAT_UW = 64'h50A8_8888_0609_0909;
    localparam logic [63:0] PAT_X  = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] PAT_Y  = 64'h8000_0000_0000_0001;
    localparam logic [63:0] PAT_6  = 64'h0F0F_F0F0_3C3C_C3C3;
    localparam logic [63:0] PAT_8  = 64'h1234_5678_9ABC_DEF0;

    int checks = 0;
    int errors = 0;
    int serr_pending = 0;
    logic [63:0] exp_q[$];

    // Current frame content: pattern, dead-cell colour (0 black, 1 white,
    // 2 yellow), optional short line and single-pixel colour flip.
    logic [63:0] cur_pat;
    int          bg_mode;
    int          short_ty;
    int          glitch_x;
    int          glitch_y;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pixel(input int tx, input int ty);
        logic       hs_n;
        logic       vs_n;
        logic [2:0] hi;
        logic [2:0] lo;
        logic       cell_alive;
        hs_n = !(tx >= 656 && tx <= 751);
        vs_n = !(ty == 490 || ty == 491);
        hi = 3'b000;
        lo = 3'b000;
        if (tx >= 120 && tx < 520 && ty >= 40 && ty < 440) begin
            cell_alive = cur_pat[((ty - 40) / 50) * 8 + (tx - 120) / 50];
            if (tx == glitch_x && ty == glitch_y) begin
                cell_alive = !cell_alive;
            end
            if (cell_alive) begin
                hi = 3'b011;      // {B0,G0,R0}
                lo = 3'b001;      // {B1,G1,R1}
            end else if (bg_mode == 1) begin
                hi = 3'b111;
                lo = 3'b111;
            end else if (bg_mode == 2) begin
                hi = 3'b011;      // R=11 G=11 B=00
                lo = 3'b011;
            end
        end
        return {hs_n, hi, vs_n, lo};
    endfunction

    task automatic run_lines(input int y0, input int y1);
        int last;
        for (int ty = y0; ty <= y1; ty++) begin
            last = (ty == short_ty) ? 798 : 799;
            for (int tx = 0; tx <= last; tx++) begin
                vga_in = pixel(tx, ty);
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic idle(input int n);
        vga_in = 8'b1000_1000;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [63:0] e;
        if (frame_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame_valid actual=%h expected=none", board);
            end else begin
                e = exp_q.pop_front();
                check("board", board, e);
`ifdef VGA_CAPTURE_POPCOUNT_EN
                check("live_count", 64'(live_count), 64'($countones(e)));
`endif
            end
        end
        if (sync_err) begin
            checks++;
            if (serr_pending > 0) begin
                serr_pending--;
            end else begin
                errors++;
                $display("FAIL unexpected_sync_err actual=1 expected=0");
            end
        end
    end

    initial begin
        #250_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        vga_in   = 8'b1000_1000;
        cur_pat  = 64'd0;
        bg_mode  = 0;
        short_ty = -1;
        glitch_x = -1;
        glitch_y = -1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_board", board, 64'd0);
        check("rst_frame_valid", 64'(frame_valid), 64'd0);
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_sync_err", 64'(sync_err), 64'd0);
        reset = 1'b1;

        // F0: line lock, then LOCKED at its vsync; not published
        cur_pat = PAT_UW;
        run_lines(0, 299);
        check("synced_not_locked", 64'(locked), 64'd0);
        run_lines(300, 524);

        // F1: first published frame
        exp_q.push_back(PAT_UW);
        run_lines(0, 0);
        check("locked_after_vsync", 64'(locked), 64'd1);
        run_lines(1, 524);

        // F2: all white, alive-coloured glitch one pixel right of cell (0,0) centre
        cur_pat  = 64'd0;
        bg_mode  = 1;
        glitch_x = 146;
        glitch_y = 65;
        exp_q.push_back(64'd0);
        run_lines(0, 524);

        // F3: all alive, dead glitch one pixel left of cell (0,0) centre
        cur_pat  = '1;
        bg_mode  = 0;
        glitch_x = 144;
        exp_q.push_back('1);
        run_lines(0, 524);
        glitch_x = -1;

        // F4: one 799-clock line while locked
        cur_pat  = PAT_X;
        short_ty = 100;
        serr_pending++;
        run_lines(0, 105);
        check("locked_after_short_line", 64'(locked), 64'd0);
        run_lines(106, 524);
        short_ty = -1;

        // F5: recovery, yellow (near-alive) background reads dead
        cur_pat = PAT_Y;
        bg_mode = 2;
        exp_q.push_back(PAT_Y);
        run_lines(0, 0);
        check("locked_recovered", 64'(locked), 64'd1);
        run_lines(1, 524);

        // hsync stuck high: saturation drops lock
        serr_pending++;
        idle(2000);
        check("locked_after_stall", 64'(locked), 64'd0);

        // F6: relock from saturation, not published
        cur_pat = PAT_6;
        bg_mode = 1;
        run_lines(0, 524);

        // F7: reset mid-frame at line 200
        run_lines(0, 0);
        check("locked_relock", 64'(locked), 64'd1);
        run_lines(1, 199);
        reset = 1'b0;
        run_lines(200, 200);
        reset = 1'b1;
        check("midrst_board", board, 64'd0);
        check("midrst_locked", 64'(locked), 64'd0);
        run_lines(201, 524);

        // F8: first frame published after re-lock
        cur_pat = PAT_8;
        bg_mode = 0;
        exp_q.push_back(PAT_8);
        run_lines(0, 524);
        idle(20);

        check("frames_outstanding", 64'(exp_q.size()), 64'd0);
        check("sync_err_outstanding", 64'(serr_pending), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
